// File: rtl/alu_pkg.sv
// Shared definitions for the add/sub result word and the BCD readout stage.
package alu_pkg;

  // Field positions inside the 12-bit tagged result word.
  localparam int unsigned OP_HI    = 11;
  localparam int unsigned OP_LO    = 10;
  localparam int unsigned SIGN_BIT = 8;
  localparam int unsigned MAG_HI   = 7;

  // Operation tags carried through unaltered.
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_ADDSUB = 2'b01;
  localparam logic [1:0] OP_LOGIC  = 2'b10;
  localparam logic [1:0] OP_SHIFT  = 2'b11;

  // Conversion FSM encoding.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/alu_result_bcd_if.sv
// Producer-side and consumer-side handshake bundle of the BCD readout stage.
interface alu_result_bcd_if #(
  parameter int unsigned MAG_W  = 8,
  parameter int unsigned DIGITS = 3
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [MAG_W+3:0]      in_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            out_op;
  logic                  out_neg;
  logic [4*DIGITS-1:0]   out_bcd;

  // Converter side.
  modport slave (
    input  in_valid,
    input  in_result,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_op,
    output out_neg,
    output out_bcd
  );

  // Producer / consumer side.
  modport master (
    output in_valid,
    output in_result,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_op,
    input  out_neg,
    input  out_bcd
  );

endinterface

// File: rtl/bcd_adjust_digit.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_adjust_digit (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Correct the digit so the following left shift carries properly into the next digit.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/alu_result_bcd.sv
// Iterative double-dabble converter for the sign-magnitude add/sub result word.
module alu_result_bcd
  import alu_pkg::*;
#(
  parameter int unsigned MAG_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic              clk,
  input logic              rst,
  alu_result_bcd_if.slave  bus
);

  localparam int unsigned BcdW    = 4 * DIGITS;
  localparam int unsigned CntW    = $clog2(MAG_W + 1);
  localparam int unsigned SignBit = MAG_W;
  localparam int unsigned OpLo    = MAG_W + 2;
  localparam int unsigned OpHi    = MAG_W + 3;

  // The digit field must hold the largest magnitude, otherwise the top digit overflows.
  if (10 ** DIGITS <= (2 ** MAG_W) - 1) begin : g_range_chk
    $error("alu_result_bcd: DIGITS too small for MAG_W");
  end

  bcd_state_e            r_state;
  bcd_state_e            w_state_d;
  logic [CntW-1:0]       r_cnt;
  logic [BcdW-1:0]       r_bcd;
  logic [MAG_W-1:0]      r_mag;
  logic [1:0]            r_op;
  logic                  r_neg;
  logic [1:0]            r_out_op;
  logic                  r_out_neg;
  logic [BcdW-1:0]       r_out_bcd;
  logic [BcdW-1:0]       w_adj;
  logic [BcdW+MAG_W-1:0] w_shift;
  logic                  w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adjust_digit u_adj (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Adjusted digits and remaining magnitude shifted left as one register.
  assign w_shift = {w_adj[BcdW-2:0], r_mag, 1'b0};
  // All MAG_W steps taken; this cycle publishes the result.
  assign w_last  = (r_cnt == CntW'(MAG_W));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (bus.in_valid)  w_state_d = StConv;
      StConv:  if (w_last)        w_state_d = StDone;
      StDone:  if (bus.out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.in_ready  = (r_state == StIdle);
    bus.out_valid = (r_state == StDone);
  end

  // Capture, shift steps and result publication; bit MAG_W+1 of the word is never sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_mag     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_out_op  <= '0;
      r_out_neg <= 1'b0;
      r_out_bcd <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_op  <= bus.in_result[OpHi:OpLo];
            // Negative zero is reported as plain zero.
            r_neg <= bus.in_result[SignBit] & (|bus.in_result[MAG_W-1:0]);
            r_mag <= bus.in_result[MAG_W-1:0];
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        StConv: begin
          if (w_last) begin
            r_out_op  <= r_op;
            r_out_neg <= r_neg;
            r_out_bcd <= r_bcd;
          end else begin
            {r_bcd, r_mag} <= w_shift;
            r_cnt          <= r_cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_op  = r_out_op;
  assign bus.out_neg = r_out_neg;
  assign bus.out_bcd = r_out_bcd;

endmodule
